// File: rtl/sipo_nibble_receiver_pkg.sv
// Shared types and constants for the serial-to-parallel receive stage.
// Pure declarations: no latency, no backpressure.
package sipo_rx_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 2;

  // Counter must hold 0..WIDTH inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_nibble_receiver_if.sv
// Serial-in / word-out bus with status; slave side is the receiver.
// Wiring only: no latency; Out_Ready backpressures the word side.
interface sipo_nibble_receiver_if #(
  parameter int WIDTH = sipo_rx_pkg::DEF_WIDTH
);
  logic             Serial_In;
  logic             Bit_Valid;
  logic             Frame_Start;
  logic [WIDTH-1:0] Parallel_Out;
  logic             Out_Valid;
  logic             Out_Ready;
  logic             Overflow;
  logic             Frame_Error;

  modport master (
    output Serial_In, Bit_Valid, Frame_Start, Out_Ready,
    input  Parallel_Out, Out_Valid, Overflow, Frame_Error
  );

  modport slave (
    input  Serial_In, Bit_Valid, Frame_Start, Out_Ready,
    output Parallel_Out, Out_Valid, Overflow, Frame_Error
  );
endinterface

// File: rtl/sipo_nibble_receiver_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head read combinationally from storage.
// Write visible at head one cycle later; a push when full is accepted only alongside a pop.
module sync_fifo #(
  parameter int W = 4,
  parameter int D = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(D);

  logic [W-1:0] mem_q [D];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end
endmodule

// File: rtl/sipo_nibble_receiver.sv
// MSB-first serial to WIDTH-bit word receiver with frame alignment and output FIFO.
// Word visible one cycle after its last bit; Out_Ready stalls the FIFO, overflow drops and flags.
module sipo_nibble_receiver
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                  Clk,
  input  logic                  Rst,
  sipo_nibble_receiver_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             ferr_q, ferr_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] word;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head;
  logic             fifo_empty, fifo_full;

  assign word = {shift_q[WIDTH-2:0], bus.Serial_In};
  assign pop  = bus.Out_Ready & ~fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    push    = 1'b0;
    if (bus.Bit_Valid) begin
      unique case (state_q)
        HUNT: begin
          if (bus.Frame_Start) begin
            shift_d = {{(WIDTH-1){1'b0}}, bus.Serial_In};
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          // Frame_Start overrides even the completing bit of a partial word.
          if (bus.Frame_Start) begin
            ferr_d  = (cnt_q != '0);
            shift_d = {{(WIDTH-1){1'b0}}, bus.Serial_In};
            cnt_d   = CW'(1);
          end else begin
            shift_d = word;
            if (cnt_q == CW'(WIDTH-1)) begin
              push  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    ovf_d = ovf_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .W(WIDTH),
    .D(DEPTH)
  ) u_fifo (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .push_i     (push),
    .push_dat_i (word),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  assign bus.Out_Valid    = ~fifo_empty;
  assign bus.Parallel_Out = fifo_empty ? '0 : head;
  assign bus.Overflow     = ovf_q;
  assign bus.Frame_Error  = ferr_q;
endmodule
